// File: rtl/audio_i2s_rx_pkg.sv
// Shared types for the I2S ADC receiver: sample width, channel tag and receive FSM states.
package audio_pkg;

  localparam int SAMPLE_W = 16;

  typedef enum logic {CH_RIGHT = 1'b0, CH_LEFT = 1'b1} chan_t;

  typedef enum logic [1:0] {RX_IDLE, RX_SKIP, RX_SHIFT, RX_WAIT} i2s_rx_state_t;

  // lrclk low marks the left slot
  function automatic chan_t lr_to_chan(input logic lr);
    return lr ? CH_RIGHT : CH_LEFT;
  endfunction

endpackage

// File: rtl/audio_i2s_rx_if.sv
// Sample output handshake between the I2S receiver (master) and the sample-storage stage (slave).
interface audio_i2s_rx_if
  import audio_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W
);

  logic signed [DATA_W-1:0] odata;
  logic                     ochannel;
  logic                     ovalid;
  logic                     oready;

  modport master (output odata, output ochannel, output ovalid, input oready);
  modport slave  (input odata, input ochannel, input ovalid, output oready);

endinterface

// File: rtl/audio_i2s_rx_sync2.sv
// Two-flop synchroniser bank for asynchronous codec inputs; resets to zero.
module audio_sync2 #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/audio_i2s_rx.sv
// WM8731 I2S ADC receiver: deserialises bclk/lrclk/adcdat into channel-tagged samples in the clk50 domain.
// Optional macro AUDIO_I2S_RX_OVF_CNT_EN adds a saturating dropped-sample counter on ovf_cnt.
module audio_i2s_rx
  import audio_pkg::*;
#(
  parameter int DATA_W   = SAMPLE_W,
  parameter int MIN_BCLK = 8
) (
  input  logic                 clk50,
  input  logic                 rst,
  input  logic                 bclk,
  input  logic                 lrclk,
  input  logic                 adcdat,
  audio_i2s_rx_if.master       smp,
  output logic                 ovf,
  output logic [15:0]          ovf_cnt
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 2);

  if (MIN_BCLK < 4) begin : g_min_bclk_chk
    $error("audio_i2s_rx: MIN_BCLK must allow two clk50 cycles per bclk phase");
  end

  logic [2:0] sync_w;
  logic       bclk_hist_q;
  logic       bclk_rise;
  logic       lr_s;
  logic       dat_s;
  logic       lr_chg;

  i2s_rx_state_t     state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  chan_t             chan_q, chan_d;
  logic              last_lr_q, last_lr_d;
  logic              lr_seen_q, lr_seen_d;
  logic              load_q, load_d;

  logic signed [DATA_W-1:0] odata_q, odata_d;
  logic                     ochan_q, ochan_d;
  logic                     ovalid_q, ovalid_d;
  logic                     ovf_q, ovf_d;

  audio_sync2 #(.WIDTH(3)) u_sync (
    .clk (clk50),
    .rst (rst),
    .d_i ({bclk, lrclk, adcdat}),
    .q_o (sync_w)
  );

  assign bclk_rise = sync_w[2] & ~bclk_hist_q;
  assign lr_s      = sync_w[1];
  assign dat_s     = sync_w[0];
  assign lr_chg    = lr_s ^ last_lr_q;

  // The rise that first shows a new lrclk level is the I2S delay bit, so the rise
  // taken in RX_SKIP already carries the MSB. lr_seen_q keeps the first rise after
  // reset from being mistaken for a slot boundary.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    chan_d    = chan_q;
    last_lr_d = last_lr_q;
    lr_seen_d = lr_seen_q;
    load_d    = 1'b0;
    if (bclk_rise) begin
      last_lr_d = lr_s;
      lr_seen_d = 1'b1;
      case (state_q)
        RX_IDLE: begin
          if (lr_seen_q && lr_chg) begin
            state_d = RX_SKIP;
            chan_d  = lr_to_chan(lr_s);
          end
        end
        RX_SKIP: begin
          shift_d = {shift_q[DATA_W-2:0], dat_s};
          cnt_d   = '0;
          state_d = RX_SHIFT;
        end
        RX_SHIFT: begin
          if (lr_chg) begin
            state_d = RX_SKIP;
            chan_d  = lr_to_chan(lr_s);
          end else begin
            shift_d = {shift_q[DATA_W-2:0], dat_s};
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
              load_d  = 1'b1;
              state_d = RX_WAIT;
            end
          end
        end
        RX_WAIT: begin
          if (lr_chg) begin
            state_d = RX_SKIP;
            chan_d  = lr_to_chan(lr_s);
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  // A consumer accept and a new load may coincide; only a load into a held,
  // unaccepted sample is a drop.
  always_comb begin
    odata_d  = odata_q;
    ochan_d  = ochan_q;
    ovalid_d = ovalid_q;
    ovf_d    = ovf_q;
    if (load_q) begin
      if (!ovalid_q || smp.oready) begin
        odata_d  = $signed(shift_q);
        ochan_d  = chan_q;
        ovalid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (ovalid_q && smp.oready) begin
      ovalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      bclk_hist_q <= 1'b0;
      state_q     <= RX_IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      chan_q      <= CH_RIGHT;
      last_lr_q   <= 1'b0;
      lr_seen_q   <= 1'b0;
      load_q      <= 1'b0;
      odata_q     <= '0;
      ochan_q     <= 1'b0;
      ovalid_q    <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      bclk_hist_q <= sync_w[2];
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      chan_q      <= chan_d;
      last_lr_q   <= last_lr_d;
      lr_seen_q   <= lr_seen_d;
      load_q      <= load_d;
      odata_q     <= odata_d;
      ochan_q     <= ochan_d;
      ovalid_q    <= ovalid_d;
      ovf_q       <= ovf_d;
    end
  end

`ifdef AUDIO_I2S_RX_OVF_CNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;
  logic        drop;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign drop      = load_q & ovalid_q & ~smp.oready;
  assign ovf_cnt_d = drop ? sat_inc(ovf_cnt_q) : ovf_cnt_q;

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) ovf_cnt_q <= '0;
    else     ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_cnt = ovf_cnt_q;
`else
  assign ovf_cnt = 16'd0;
`endif

  assign smp.odata    = odata_q;
  assign smp.ochannel = ochan_q;
  assign smp.ovalid   = ovalid_q;
  assign ovf          = ovf_q;

endmodule

// File: tb/tb_audio_i2s_rx.sv
// Scoreboard bench for audio_i2s_rx: directed I2S slots, expected samples queued at issue, monitor pops on transfer.
module tb_audio_i2s_rx;

  logic        clk50 = 1'b0;
  logic        rst;
  logic        bclk;
  logic        lrclk;
  logic        adcdat;
  logic        ovf;
  logic [15:0] ovf_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  logic [16:0] exp_q[$];

`ifdef AUDIO_I2S_RX_OVF_CNT_EN
  localparam logic [15:0] EXP_DROPS = 16'd2;
`else
  localparam logic [15:0] EXP_DROPS = 16'd0;
`endif

  audio_i2s_rx_if #(.DATA_W(16)) bus ();

  audio_i2s_rx #(.DATA_W(16), .MIN_BCLK(8)) dut (
    .clk50   (clk50),
    .rst     (rst),
    .bclk    (bclk),
    .lrclk   (lrclk),
    .adcdat  (adcdat),
    .smp     (bus.master),
    .ovf     (ovf),
    .ovf_cnt (ovf_cnt)
  );

  always #10 clk50 = ~clk50;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: one transfer per cycle where ovalid and oready are both high
  always @(negedge clk50) begin
    if (rst === 1'b0 && bus.ovalid === 1'b1 && bus.oready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got ch%0d %h expected no sample", bus.ochannel, bus.odata);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        chk("sample", {15'd0, bus.ochannel, bus.odata}, {15'd0, e});
      end
    end
  end

  task automatic bit_lo(input logic lr, input logic d);
    bclk   = 1'b0;
    lrclk  = lr;
    adcdat = d;
    repeat (8) @(negedge clk50);
  endtask

  task automatic bit_full(input logic lr, input logic d);
    bit_lo(lr, d);
    bclk = 1'b1;
    repeat (8) @(negedge clk50);
  endtask

  // mode 0: plain slot; 1: latency check on LSB; 2: oready pulsed into the load cycle
  task automatic slot(input logic lr, input logic [15:0] w, input int ndata, input int total,
                      input int mode);
    bit_full(lr, 1'b0);
    for (int i = 0; i < ndata; i++) begin
      if (i == ndata - 1 && mode != 0) begin
        bit_lo(lr, w[15-i]);
        bclk = 1'b1;
        repeat (3) @(posedge clk50);
        #1;
        if (mode == 1) begin
          chk("lat_before", 32'(bus.ovalid), 32'd0);
          @(posedge clk50);
          #1;
          chk("lat_ovalid", 32'(bus.ovalid), 32'd1);
          chk("lat_data", {16'd0, bus.odata}, {16'd0, w});
        end else begin
          bus.oready = 1'b1;
          @(posedge clk50);
          #1;
          chk("bb_ovalid", 32'(bus.ovalid), 32'd1);
          chk("bb_data", {16'd0, bus.odata}, {16'd0, w});
          chk("bb_ovf", 32'(ovf), 32'd0);
          bus.oready = 1'b0;
        end
        repeat (8) @(negedge clk50);
      end else begin
        bit_full(lr, w[15-i]);
      end
    end
    for (int i = ndata + 1; i < total; i++) bit_full(lr, 1'b0);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_odata"}, {16'd0, bus.odata}, 32'd0);
    chk({nm, "_ochannel"}, 32'(bus.ochannel), 32'd0);
    chk({nm, "_ovalid"}, 32'(bus.ovalid), 32'd0);
    chk({nm, "_ovf"}, 32'(ovf), 32'd0);
    chk({nm, "_ovf_cnt"}, {16'd0, ovf_cnt}, 32'd0);
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  initial begin
    #5000000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: got timeout expected test end");
    summary();
    $finish;
  end

  initial begin
    logic [15:0] w;
    rst        = 1'b1;
    bclk       = 1'b0;
    lrclk      = 1'b1;
    adcdat     = 1'b0;
    bus.oready = 1'b0;
    repeat (3) @(posedge clk50);
    #1;
    check_zero("reset");
    rst = 1'b0;
    repeat (4) bit_full(1'b1, 1'b0);

    // Left then right with consumer always ready, latency measured on each LSB
    bus.oready = 1'b1;
    exp_q.push_back({1'b1, 16'h1234});
    slot(1'b0, 16'h1234, 16, 20, 1);
    exp_q.push_back({1'b0, 16'hABCD});
    slot(1'b1, 16'hABCD, 16, 20, 1);
    chk("t1_ovf", 32'(ovf), 32'd0);

    // Short slot discarded, next full slot captured
    slot(1'b0, 16'hFFFF, 9, 10, 0);
    exp_q.push_back({1'b0, 16'h5A5A});
    slot(1'b1, 16'h5A5A, 16, 20, 0);

    // Held sample stays stable; accept and new load in the same cycle
    @(posedge clk50);
    #1 bus.oready = 1'b0;
    exp_q.push_back({1'b1, 16'h1111});
    slot(1'b0, 16'h1111, 16, 20, 0);
    chk("hold_ovalid", 32'(bus.ovalid), 32'd1);
    chk("hold_data", {16'd0, bus.odata}, 32'h1111);
    exp_q.push_back({1'b0, 16'h2222});
    slot(1'b1, 16'h2222, 16, 20, 2);
    @(posedge clk50);
    #1 bus.oready = 1'b1;
    repeat (3) @(posedge clk50);
    #1 bus.oready = 1'b0;
    chk("bb_drained", 32'(bus.ovalid), 32'd0);

    // Three slots with consumer stalled: first kept, two dropped
    exp_q.push_back({1'b1, 16'h0001});
    slot(1'b0, 16'h0001, 16, 20, 0);
    slot(1'b1, 16'h0002, 16, 20, 0);
    slot(1'b0, 16'h0003, 16, 20, 0);
    chk("ovf_data", {16'd0, bus.odata}, 32'h0001);
    chk("ovf_chan", 32'(bus.ochannel), 32'd1);
    chk("ovf_ovalid", 32'(bus.ovalid), 32'd1);
    chk("ovf_flag", 32'(ovf), 32'd1);
    chk("ovf_cnt", {16'd0, ovf_cnt}, {16'd0, EXP_DROPS});
    @(posedge clk50);
    #1 bus.oready = 1'b1;
    repeat (3) @(posedge clk50);
    #1;
    chk("ovf_drained", 32'(bus.ovalid), 32'd0);
    chk("ovf_sticky", 32'(ovf), 32'd1);

    // Reset in the middle of a right slot
    w = 16'h7777;
    bit_full(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) bit_full(1'b1, w[15-i]);
    @(posedge clk50);
    #1 rst = 1'b1;
    #1;
    check_zero("midrst");
    repeat (3) @(posedge clk50);
    #1 rst = 1'b0;
    for (int i = 5; i < 16; i++) bit_full(1'b1, w[15-i]);
    repeat (3) bit_full(1'b1, 1'b0);
    exp_q.push_back({1'b1, 16'h0F0F});
    slot(1'b0, 16'h0F0F, 16, 20, 0);
    repeat (10) @(posedge clk50);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("post_rst_ovf", 32'(ovf), 32'd0);

    summary();
    $finish;
  end

endmodule
